// File: rtl/ifetch_prefetch_if.sv
// Signal bundle between the instruction prefetcher, the instruction memory port,
// the redirect source and the decode stage.
interface ifetch_prefetch_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_bdone;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output ibus_req, ibus_addr, inst_valid, inst, inst_pc,
        input  ibus_rdata, ibus_bdone, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  ibus_req, ibus_addr, inst_valid, inst, inst_pc,
        output ibus_rdata, ibus_bdone, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: sequential word fetch into a small {pc, word} FIFO,
// flushed and restarted by redirects.
module ifetch_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    ifetch_prefetch_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_fpc;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [31:0]        r_pc_mem   [DEPTH];
    logic [31:0]        r_word_mem [DEPTH];

    logic               w_ibus_req;
    logic               w_push;
    logic               w_pop;
    logic               w_inst_valid;
    logic [31:0]        w_redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ibus_req   = 1'b0;
        case (r_state)
            BOOT: w_state_next = RUN;
            RUN: begin
                w_state_next = RUN;
                w_ibus_req   = !bus.redirect_valid && (r_count < FULL);
            end
            default: w_state_next = BOOT;
        endcase
    end

    // Push/pop are qualified by redirect so a flush cycle drops both.
    assign w_push        = w_ibus_req && bus.ibus_bdone;
    assign w_inst_valid  = (r_count != '0);
    assign w_pop         = w_inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    assign bus.ibus_req   = w_ibus_req;
    assign bus.ibus_addr  = r_fpc;
    assign bus.inst_valid = w_inst_valid;
    assign bus.inst       = r_word_mem[r_rd_ptr];
    assign bus.inst_pc    = r_pc_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc    <= RESET_PC;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.redirect_valid) begin
            r_fpc    <= w_redirect_pc;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_fpc    <= r_fpc + 32'd4;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-entry storage; only the slot under the write pointer takes a push.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_pc_mem[gi]   <= r_fpc;
                    r_word_mem[gi] <= bus.ibus_rdata;
                end
            end
        end
    endgenerate
endmodule

// File: doc/ifetch_prefetch.md
IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] SHALL be 0).
REQ-002 SHALL have parameter DEPTH, default 2, meaning prefetch buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ibus_req  output  1  read request to the instruction memory port (ttype READ).
REQ-006 SHALL have port ibus_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port ibus_rdata  input  32  instruction word returned for ibus_addr.
REQ-008 SHALL have port ibus_bdone  input  1  transfer complete; ibus_rdata valid this cycle.
REQ-009 SHALL have port redirect_valid  input  1  flush and restart fetch (branch/jump/trap).
REQ-010 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-011 SHALL have port inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port inst_ready  input  1  decode accepts head this cycle.
REQ-013 SHALL have port inst  output  32  instruction word at buffer head.
REQ-014 SHALL have port inst_pc  output  32  address of the instruction at buffer head.

Function
REQ-015 SHALL implement a two-state FSM: BOOT (entered on rst, no requests) and RUN; BOOT -> RUN unconditionally on the first cycle with rst low; RUN -> BOOT only on rst.
REQ-016 SHALL keep fetch PC register fpc and a DEPTH-entry FIFO of {pc, word} with a count register (0..DEPTH).
REQ-017 SHALL drive ibus_req = (state==RUN) && !redirect_valid && (count < DEPTH); ibus_addr = fpc at all times.
REQ-018 SHALL, on a cycle with ibus_req && ibus_bdone, push {fpc, ibus_rdata} and set fpc <= fpc + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL, when ibus_req && !ibus_bdone, hold fpc and ibus_addr stable and push nothing (wait states of any length).
REQ-020 SHALL drive inst_valid = (count != 0); inst/inst_pc from the head entry; inst/inst_pc are don't-care when inst_valid=0.
REQ-021 SHALL pop the head on inst_valid && inst_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-022 SHALL never push when count == DEPTH, even if a pop occurs the same cycle (no same-cycle bypass into a full buffer).
REQ-023 SHALL, on redirect_valid in RUN or BOOT, set count <= 0, reset FIFO pointers, set fpc <= {redirect_pc[31:2], 2'b00}; any pop or bus response in that cycle SHALL be discarded.
REQ-024 SHALL give latency: request at cycle t with bdone=1 -> inst_valid at t+1; redirect at cycle k -> ibus_req to new PC at k+1, its inst_valid earliest at k+2.
REQ-025 SHALL give rst priority over redirect_valid and all other inputs.
REQ-026 SHALL sustain one instruction per cycle when ibus_bdone=1 and inst_ready=1 continuously.

Reset
REQ-027 SHALL, on rst high at a clock edge, set state=BOOT, fpc=RESET_PC, count=0, FIFO pointers=0; ibus_req=0 and inst_valid=0 in the following cycle.
REQ-028 SHALL, on rst mid-transfer (bdone low or high), discard the transfer and all buffered entries; no entry is pushed in the rst cycle.

Verification
REQ-029 SHALL cover boot: rst 2 cycles, bdone=1, ready=1 -> ibus_addr 0x0,0x4,0x8 on consecutive cycles; inst_pc 0x0 valid one cycle after first request.
REQ-030 SHALL cover backpressure: ready=0, DEPTH=2 -> exactly 2 pushes (pc 0x0,0x4), ibus_req drops, fpc holds 0x8; ready=1 -> pops in order 0x0,0x4, refetch 0x8.
REQ-031 SHALL cover wait states: bdone low 3 cycles at addr 0x10 -> addr stays 0x10, no push; bdone high -> push pc 0x10, next addr 0x14.
REQ-032 SHALL cover redirect: buffer full (0x20,0x24), redirect_pc=0x103 with ready=1 -> inst_valid 0 next cycle, ibus_addr 0x100, inst_pc 0x100 valid following cycle; no 0x20/0x24 delivered.
REQ-033 SHALL cover wrap: redirect_pc=0xFFFF_FFFC -> fetched pcs 0xFFFF_FFFC then 0x0000_0000.
REQ-034 SHALL cover rst asserted with 2 buffered entries and bdone=0 -> inst_valid 0, ibus_req 0, next fetch address RESET_PC.
